// File: rtl/syn_fifo.sv
// ============================================================================
// syn_fifo : single-clock FIFO with occupancy count, watermarks, error pulses
//            and optional first-word-fall-through read mode.
// Rev 1.0
// ============================================================================
`default_nettype none

module syn_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int AFULL_THR  = 6,
    parameter int AEMPTY_THR = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     data_cnt,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]    AFULL_C  = (AW+1)'(AFULL_THR);
    localparam logic [AW:0]    AEMPTY_C = (AW+1)'(AEMPTY_THR);
    localparam logic [AW-1:0]  PTR_INC  = (AW)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] hold_data;
    logic             rd_acc;
    logic             wr_acc;
    logic [AW:0]      cnt_next;

    // A write into a full FIFO is legal only when a pop frees a slot this cycle.
    always_comb begin
        rd_acc   = rd_en & ~fifo_empty;
        wr_acc   = wr_en & (~fifo_full | rd_acc);
        cnt_next = data_cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_cnt     <= '0;
            hold_data    <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_INC;
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + PTR_INC;
                hold_data <= mem[rd_ptr];
            end
            data_cnt     <= cnt_next;
            fifo_full    <= (cnt_next == DEPTH_C);
            fifo_empty   <= (cnt_next == '0);
            almost_full  <= (cnt_next >= AFULL_C);
            almost_empty <= (cnt_next <= AEMPTY_C);
            overflow     <= wr_en & ~wr_acc;
            underflow    <= rd_en & fifo_empty;
        end
    end

    // hold_data carries the last popped word: the registered output in standard
    // mode, and the value parked on rd_data while an FWFT FIFO is empty.
    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = fifo_empty ? hold_data : mem[rd_ptr];
        end else begin : g_std
            assign rd_data = hold_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_syn_fifo.sv
// ============================================================================
// tb_syn_fifo : table-driven check of syn_fifo in standard mode plus a
//               directed first-word-fall-through sequence.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_syn_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // standard-mode instance
    logic       rst, wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] data_cnt;

    // FWFT instance
    logic       f_rst, f_wr_en, f_rd_en;
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [3:0] f_cnt;

    syn_fifo #(.WIDTH(8), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .data_cnt(data_cnt),
        .overflow(overflow), .underflow(underflow)
    );

    syn_fifo #(.WIDTH(8), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(1)) dut_f (
        .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty), .data_cnt(f_cnt),
        .overflow(f_ovf), .underflow(f_udf)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [7:0] rdata;
        int         cnt;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] wd,
                       input logic [7:0] rdata, input int cnt, input logic ov, input logic un);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.wd = wd;
        v.rdata = rdata; v.cnt = cnt; v.ov = ov; v.un = un;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step%0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;

        // reset, fill to full, overflow
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(8'h11 + i), 8'h00, i + 1, 0, 0);
        add(0, 1, 0, 8'h19, 8'h00, 8, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 8, 0, 0);
        // drain, then underflow with rd_data held
        for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 8'(8'h11 + i), 7 - i, 0, 0);
        add(0, 0, 1, 8'h00, 8'h18, 0, 0, 1);
        add(0, 0, 0, 8'h00, 8'h18, 0, 0, 0);
        // wrap-around
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'(8'h01 + i), 8'h18, i + 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 8'h00, 8'(8'h01 + i), 4 - i, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(8'h21 + i), 8'h05, i + 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 8'(8'h21 + i), 7 - i, 0, 0);
        // simultaneous read/write at full
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(8'h31 + i), 8'h28, i + 1, 0, 0);
        add(0, 1, 1, 8'h39, 8'h31, 8, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 8'(8'h32 + i), 7 - i, 0, 0);
        // simultaneous read/write at empty
        add(0, 1, 1, 8'h40, 8'h39, 1, 0, 1);
        add(0, 0, 0, 8'h00, 8'h39, 1, 0, 0);
        add(0, 0, 1, 8'h00, 8'h40, 0, 0, 0);
        // reset mid-operation wins over a concurrent write
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'(8'h51 + i), 8'h40, i + 1, 0, 0);
        add(1, 1, 0, 8'h77, 8'h00, 0, 0, 0);
        add(0, 1, 0, 8'h3C, 8'h00, 1, 0, 0);
        add(0, 0, 1, 8'h00, 8'h3C, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; wr_en = vq[i].wr; rd_en = vq[i].rd; wr_data = vq[i].wd;
            @(posedge clk);
            #1;
            f_rst = 1'b0;
            check("rd_data",      i, 32'(rd_data),      32'(vq[i].rdata));
            check("data_cnt",     i, 32'(data_cnt),     32'(vq[i].cnt));
            check("fifo_full",    i, 32'(fifo_full),    32'(vq[i].cnt == 8));
            check("fifo_empty",   i, 32'(fifo_empty),   32'(vq[i].cnt == 0));
            check("almost_full",  i, 32'(almost_full),  32'(vq[i].cnt >= 6));
            check("almost_empty", i, 32'(almost_empty), 32'(vq[i].cnt <= 2));
            check("overflow",     i, 32'(overflow),     32'(vq[i].ov));
            check("underflow",    i, 32'(underflow),    32'(vq[i].un));
        end

        // FWFT: head word visible without a request, held once empty
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
        check("fwft_rst_data",  100, 32'(f_rd_data), 32'h00);
        check("fwft_rst_empty", 100, 32'(f_empty),   32'h1);
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        @(posedge clk); #1;
        check("fwft_first_empty", 101, 32'(f_empty),   32'h0);
        check("fwft_first_data",  101, 32'(f_rd_data), 32'hA5);
        @(negedge clk);
        f_wr_data = 8'h5A;
        @(posedge clk); #1;
        check("fwft_head_data", 102, 32'(f_rd_data), 32'hA5);
        check("fwft_head_cnt",  102, 32'(f_cnt),     32'h2);
        @(negedge clk);
        f_wr_en = 1'b0; f_rd_en = 1'b1;
        @(posedge clk); #1;
        check("fwft_pop_data", 103, 32'(f_rd_data), 32'h5A);
        check("fwft_pop_cnt",  103, 32'(f_cnt),     32'h1);
        @(posedge clk); #1;
        check("fwft_hold_data",  104, 32'(f_rd_data), 32'h5A);
        check("fwft_hold_empty", 104, 32'(f_empty),   32'h1);
        @(negedge clk);
        f_rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
